// File: rtl/sprite_rom_arbiter.sv
// Three-way read arbiter for the single-port sprite/picture ROM with round-robin, burst lock and a fixed 3-cycle read pipeline.
// Define ROM_ARB_SCAN_PRIO_EN to give scan-out (requester 0) absolute priority and burst pre-emption.
module sprite_rom_arbiter #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic [2:0]        req,
    input  logic [2:0]        lock,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [2:0]        gnt,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rden,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] rd_data,
    output logic [2:0]        rd_valid,
    output logic              busy
);

    localparam int unsigned      CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic {
        ARB,
        BURST
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        last_grant;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W-1:0]  cnt_d;
    logic [2:0]        gnt_c;
    logic [2:0]        owner_oh;
    logic              owner_hold;
    logic              preempt_c;
    logic [2:0]        cand;
    logic [2:0]        own1;
    logic [2:0]        own2;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        gnt_idx;

    // Round-robin search starting one past the last winner.
    function automatic logic [2:0] rr_pick(input logic [2:0] c, input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = 3'b000;
        for (int k = 1; k <= 3; k++) begin
            idx = 2'((int'(last) + k) % 3);
            if (pick == 3'b000 && c[idx]) pick[idx] = 1'b1;
        end
        return pick;
    endfunction

    function automatic logic [2:0] pick_winner(input logic [2:0] c, input logic [1:0] last);
`ifdef ROM_ARB_SCAN_PRIO_EN
        if (c[0]) return 3'b001;
`endif
        return rr_pick(c, last);
    endfunction

`ifdef ROM_ARB_SCAN_PRIO_EN
    assign preempt_c = (state_q == BURST) && req[0] && (last_grant != 2'd0);
`else
    assign preempt_c = 1'b0;
`endif

    assign owner_oh   = 3'(3'b001 << last_grant);
    assign owner_hold = |(owner_oh & req & lock);

    // Grant decision and next state of the arbitration FSM.
    always_comb begin
        gnt_c   = 3'b000;
        state_d = state_q;
        cnt_d   = burst_cnt;
        cand    = req;
        if (state_q == BURST && owner_hold && !preempt_c && burst_cnt < CNT_MAX) begin
            gnt_c = owner_oh;
            cnt_d = burst_cnt + CNT_W'(1);
        end else begin
            // Burst limit reached: step aside if anyone else is waiting.
            if (state_q == BURST && owner_hold && !preempt_c && (req & ~owner_oh) != 3'b000)
                cand = req & ~owner_oh;
            gnt_c = pick_winner(cand, last_grant);
            if (preempt_c || (gnt_c & lock) == 3'b000) begin
                state_d = ARB;
                cnt_d   = '0;
            end else begin
                state_d = BURST;
                cnt_d   = CNT_W'(1);
            end
        end
    end

    assign gnt = sys_rst ? 3'b000 : gnt_c;

    always_comb begin
        sel_addr = addr0;
        gnt_idx  = 2'd0;
        if (gnt[2]) begin
            sel_addr = addr2;
            gnt_idx  = 2'd2;
        end else if (gnt[1]) begin
            sel_addr = addr1;
            gnt_idx  = 2'd1;
        end
    end

    // FSM state, ROM request stage and return pipeline.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_q    <= ARB;
            last_grant <= 2'd2;
            burst_cnt  <= '0;
            rom_addr   <= '0;
            rom_rden   <= 1'b0;
            own1       <= 3'b000;
            own2       <= 3'b000;
            rd_data    <= '0;
            rd_valid   <= 3'b000;
            busy       <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_cnt <= cnt_d;
            if (gnt != 3'b000) begin
                last_grant <= gnt_idx;
                rom_addr   <= sel_addr;
            end
            rom_rden <= (gnt != 3'b000);
            own1     <= gnt;
            own2     <= own1;
            if (own2 != 3'b000) rd_data <= rom_q;
            rd_valid <= own2;
            busy     <= (gnt != 3'b000) || (own1 != 3'b000) || (own2 != 3'b000);
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter with a registered-output ROM model.
module tb_sprite_rom_arbiter;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    logic              vga_clk = 1'b0;
    logic              sys_rst;
    logic [2:0]        req;
    logic [2:0]        lock;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [2:0]        gnt;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rden;
    logic [DATA_W-1:0] rom_q;
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        rd_valid;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int                due;
        logic [2:0]        owner;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sb[$];

    sprite_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(16)) dut (
        .vga_clk  (vga_clk),
        .sys_rst  (sys_rst),
        .req      (req),
        .lock     (lock),
        .addr0    (addr0),
        .addr1    (addr1),
        .addr2    (addr2),
        .gnt      (gnt),
        .rom_addr (rom_addr),
        .rom_rden (rom_rden),
        .rom_q    (rom_q),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    always #20 vga_clk = ~vga_clk;

    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(42)) return 16'hF800;
        return DATA_W'(a) ^ 16'h5A3C;
    endfunction

    always @(posedge vga_clk) begin
        rom_q <= rom_word(rom_addr);
        cyc   <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Scoreboard: push on grant, pop and compare on rd_valid.
    always @(negedge vga_clk) begin
        exp_t e;
        logic [ADDR_W-1:0] a;
        if (rd_valid != 3'b000) begin
            if (sb.size() == 0) begin
                check_eq("rd_unexpected", 32'(rd_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check_eq("rd_owner", 32'(rd_valid), 32'(e.owner));
                check_eq("rd_data", 32'(rd_data), 32'(e.data));
                check_eq("rd_latency", 32'(cyc), 32'(e.due));
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            check_eq("rd_missing", 32'(rd_valid), 32'(sb[0].owner));
            void'(sb.pop_front());
        end
        if (sys_rst) begin
            sb.delete();
        end else if (gnt != 3'b000) begin
            check_eq("gnt_legal", 32'({$onehot(gnt), (gnt & ~req) == 3'b000}), 32'(2'b11));
            a = gnt[2] ? addr2 : (gnt[1] ? addr1 : addr0);
            sb.push_back('{due: cyc + 3, owner: gnt, data: rom_word(a)});
        end
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic expect_gnt(input string tag, input logic [2:0] exp);
        @(negedge vga_clk);
        check_eq(tag, 32'(gnt), 32'(exp));
        tick();
    endtask

    task automatic drain();
        req  = 3'b000;
        lock = 3'b000;
        @(negedge vga_clk);
        check_eq("busy_hi", 32'(busy), 32'(1));
        tick();
        tick();
        tick();
        @(negedge vga_clk);
        check_eq("busy_lo", 32'(busy), 32'(0));
        check_eq("sb_drained", 32'(sb.size()), 32'(0));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0] rr_seq [6];
        logic       prio;
`ifdef ROM_ARB_SCAN_PRIO_EN
        prio = 1'b1;
`else
        prio = 1'b0;
`endif
        if (prio) rr_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        else      rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        sys_rst = 1'b1;
        req     = 3'b000;
        lock    = 3'b000;
        addr0   = ADDR_W'(100);
        addr1   = ADDR_W'(200);
        addr2   = ADDR_W'(300);
        tick();
        req = 3'b111;
        @(negedge vga_clk);
        check_eq("gnt_in_reset", 32'(gnt), 32'(0));
        check_eq("rst_rom_addr", 32'(rom_addr), 32'(0));
        check_eq("rst_rom_rden", 32'(rom_rden), 32'(0));
        check_eq("rst_rd_data", 32'(rd_data), 32'(0));
        check_eq("rst_rd_valid", 32'(rd_valid), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        tick();
        sys_rst = 1'b0;

        // Plain round-robin among all three.
        for (int i = 0; i < 6; i++) expect_gnt("rr_seq", rr_seq[i]);
        drain();

        // Locked burst hits the limit, yields once, then resumes.
        req  = 3'b110;
        lock = 3'b010;
        for (int i = 0; i < 16; i++) expect_gnt("burst_lock", 3'b010);
        expect_gnt("burst_max_yield", 3'b100);
        expect_gnt("burst_resume", 3'b010);
        expect_gnt("burst_resume", 3'b010);
        drain();

        // Single read of a known ROM word.
        req   = 3'b010;
        addr1 = ADDR_W'(42);
        expect_gnt("single_gnt", 3'b010);
        req = 3'b000;
        @(negedge vga_clk);
        check_eq("rom_addr_t1", 32'(rom_addr), 32'(42));
        check_eq("rom_rden_t1", 32'(rom_rden), 32'(1));
        tick();
        @(negedge vga_clk);
        check_eq("rom_rden_idle", 32'(rom_rden), 32'(0));
        tick();
        @(negedge vga_clk);
        check_eq("rd_data_42", 32'(rd_data), 32'(16'hF800));
        check_eq("rd_valid_42", 32'(rd_valid), 32'(3'b010));
        tick();
        tick();

        // Owner 2 bursts, then drops lock while requester 1 waits.
        req  = 3'b110;
        lock = 3'b100;
        expect_gnt("b2_enter", 3'b100);
        for (int i = 0; i < 4; i++) expect_gnt("b2_hold", 3'b100);
        lock = 3'b000;
        expect_gnt("b2_drop", 3'b010);
        req = 3'b101;
        expect_gnt("arb_after_drop", prio ? 3'b001 : 3'b100);
        drain();

        // Scan-out request arriving during a requester-1 burst.
        req  = 3'b010;
        lock = 3'b010;
        for (int i = 0; i < 3; i++) expect_gnt("b1_hold", 3'b010);
        req = 3'b011;
        expect_gnt("scan_vs_burst", prio ? 3'b001 : 3'b010);
        req = prio ? 3'b010 : 3'b011;
        expect_gnt("b1_next", 3'b010);
        lock = 3'b000;
        expect_gnt("b1_end", prio ? 3'b010 : 3'b001);
        drain();

        // Reset pulse discards two in-flight reads.
        req  = 3'b111;
        lock = 3'b000;
        tick();
        tick();
        sys_rst = 1'b1;
        @(negedge vga_clk);
        check_eq("gnt_rst_mid", 32'(gnt), 32'(0));
        tick();
        sys_rst = 1'b0;
        @(negedge vga_clk);
        check_eq("post_rst_valid", 32'(rd_valid), 32'(0));
        check_eq("post_rst_busy", 32'(busy), 32'(0));
        check_eq("post_rst_rden", 32'(rom_rden), 32'(0));
        check_eq("post_rst_gnt", 32'(gnt), 32'(3'b001));
        tick();
        drain();
        tick();

        check_eq("sb_final", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 16, RGB565 pixel width.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum consecutive locked grants (range 2..255).
REQ-004 SHALL have port vga_clk  in  1  sole clock, 25 MHz; all logic on rising edge.
REQ-005 SHALL have port sys_rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req  in  3  per-requester read request; bit 0 = scan-out, bits 1-2 = sprite engines.
REQ-007 SHALL have port lock  in  3  per-requester burst-lock qualifier.
REQ-008 SHALL have ports addr0, addr1, addr2  in  ADDR_W each  requester read addresses.
REQ-009 SHALL have port gnt  out  3  one-hot combinational grant; address accepted this cycle.
REQ-010 SHALL have port rom_addr  out  ADDR_W  registered address to the single-port picture ROM.
REQ-011 SHALL have port rom_rden  out  1  registered ROM read enable.
REQ-012 SHALL have port rom_q  in  DATA_W  ROM data, valid one cycle after rom_rden.
REQ-013 SHALL have port rd_data  out  DATA_W  registered returned pixel, shared by all requesters.
REQ-014 SHALL have port rd_valid  out  3  one-hot, one cycle, marks rd_data owner.
REQ-015 SHALL have port busy  out  1  high while any read is in the pipeline.

Function
REQ-016 SHALL grant at most one requester per cycle; gnt[i] only when req[i]=1.
REQ-017 Requester SHALL hold req and addr stable until gnt; addr sampled in grant cycle T.
REQ-018 SHALL drive rom_addr=addr of winner, rom_rden=1 in T+1; rom_rden=0 in cycles with no grant at T.
REQ-019 SHALL register rom_q in T+2 and present rd_data with rd_valid[winner]=1 in T+3; fixed latency 3.
REQ-020 SHALL be fully pipelined: back-to-back grants every cycle, responses in grant order.
REQ-021 SHALL use round-robin in state ARB: search starts at last_grant+1 mod 3; last_grant updates only on a grant.
REQ-022 SHALL have states ARB and BURST; ARB->BURST when granted requester has lock=1 (burst_cnt<=1).
REQ-023 In BURST, SHALL grant only the owner while req[owner]&lock[owner]; burst_cnt increments per grant.
REQ-024 BURST->ARB when owner drops req or lock; same cycle SHALL perform ARB round-robin (owner eligible).
REQ-025 BURST->ARB when burst_cnt reaches MAX_BURST; that cycle SHALL exclude owner if any other req is high, else owner re-granted and new burst starts.
REQ-026 busy SHALL equal OR of valid flags of stages T+1, T+2, T+3.
REQ-027 req with no grant SHALL produce no ROM access; no request SHALL be dropped while held.

Reset
REQ-028 On sys_rst=1 at a clock edge: state=ARB, last_grant=2, burst_cnt=0, rom_addr=0, rom_rden=0, rd_data=0, rd_valid=0, busy=0.
REQ-029 gnt SHALL be 0 while sys_rst=1.
REQ-030 Reset mid-operation SHALL discard in-flight reads; no rd_valid after reset deasserts for pre-reset grants.

Configuration
REQ-031 Macro ROM_ARB_SCAN_PRIO_EN defined: req[0] SHALL win over requesters 1-2 regardless of last_grant and SHALL pre-empt a BURST owned by 1 or 2 (state->ARB, burst_cnt=0).
REQ-032 Macro undefined: requester 0 SHALL be an ordinary round-robin participant, no pre-emption.

Verification
REQ-033 Reset, then req=3'b111, lock=0 held 6 cycles -> gnt sequence 001,010,100,001,010,100; rd_valid same sequence shifted by 3 cycles.
REQ-034 req[1]=1, addr1=20'd42, ROM preloaded addr 42=16'hF800 -> rom_addr=42 in T+1, rd_data=16'hF800 with rd_valid=010 in T+3.
REQ-035 req=110, lock=010 held, MAX_BURST=16 -> 16 consecutive gnt=010, then one gnt=100, then burst resumes for 1.
REQ-036 Owner 2 in BURST drops lock at cycle 5 with req[1]=1 -> gnt=010 that cycle, state ARB.
REQ-037 ROM_ARB_SCAN_PRIO_EN defined, requester 1 in BURST, req[0] rises -> gnt=001 same cycle; undefined -> gnt stays 010 until burst ends.
REQ-038 sys_rst pulsed 1 cycle after two grants -> rd_valid stays 0, busy=0 next cycle, first post-reset grant to requester 0 when req=111.
